keypad_event_encoder: RTL and testbench

- Downstream consumer of the 4x4 matrix scanner's 16-bit key map (active-low, 1 = released, bit index = row*4 + col).
- Synchronises the key map, debounces each key, and detects press edges. Each press becomes a 4-bit key code in a small FWFT FIFO.
- Codes leave through a valid/ready handshake to the display/command logic.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_evt_fifo.sv | 58 +++++
 rtl/keypad_event_encoder.sv | 162 ++++++++++++++++
 tb/tb_keypad_event_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad event encoder.
// Optional build macro KEY_RELEASE_EVT_EN widens the key code to carry a
// release flag in its top bit.
package keypad_pkg;

  localparam int KEY_NUM   = 16;
  localparam int KEY_IDX_W = 4;
  // Per-key debounce counter width; holds STABLE_SAMPLES-1 for STABLE_SAMPLES <= 15.
  localparam int KEY_CNT_W = 4;

  // All keys released (scanner map is active-low).
  localparam logic [KEY_NUM-1:0] KEY_MAP_RST = 16'hffff;

`ifdef KEY_RELEASE_EVT_EN
  localparam int KEY_CODE_W = KEY_IDX_W + 1;
`else
  localparam int KEY_CODE_W = KEY_IDX_W;
`endif

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [KEY_IDX_W-1:0] lowest_idx(input logic [KEY_NUM-1:0] vec);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small first-word-fall-through FIFO for key events.
// The head entry is presented combinationally while valid; a pop advances it.
// Push while full is accepted only when a pop happens in the same cycle.
module keypad_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop & o_valid;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Head is forced to zero while empty so the output is defined after reset.
  assign o_head = o_valid ? r_mem[r_rd_ptr] : '0;

  // Event storage; contents are only observed through valid entries.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Keypad event encoder: synchronises the scanner key map, debounces each key
// on a slow sample tick, turns press edges into key codes and queues them in
// a FWFT FIFO behind a valid/ready handshake.
// Optional build macro KEY_RELEASE_EVT_EN: release edges also become events,
// flagged by key_code[4].
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int SAMPLE_DIV     = 60000,
  parameter int STABLE_SAMPLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               key_ready,
  output logic               key_valid,
  output key_code_t          key_code,
  output logic [KEY_NUM-1:0] key_state,
  output logic               overflow
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [KEY_CNT_W-1:0] CNT_LAST  = KEY_CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [KEY_NUM-1:0]   ONE_VEC   = KEY_NUM'(1);

  // Synchroniser, sample tick and debounce state
  logic [KEY_NUM-1:0]   r_sync1;
  logic [KEY_NUM-1:0]   r_sync2;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [KEY_NUM-1:0]   r_stable;
  logic [KEY_CNT_W-1:0] r_cnt [KEY_NUM];
  logic [KEY_NUM-1:0]   r_key_state;

  // Event capture
  logic [KEY_NUM-1:0]   r_press_pend;
  logic                 r_overflow;

  logic                 w_tick;
  logic [KEY_NUM-1:0]   w_differ;
  logic [KEY_NUM-1:0]   w_accept;
  logic [KEY_NUM-1:0]   w_stable_next;
  logic [KEY_CNT_W-1:0] w_cnt_next [KEY_NUM];
  logic [KEY_NUM-1:0]   w_press;
  logic [KEY_NUM-1:0]   w_press_sel;
  logic [KEY_NUM-1:0]   w_press_clr;
  logic                 w_press_lost;
  logic                 w_rel_lost;
  logic                 w_any_pend;
  logic                 w_push;
  key_code_t            w_push_code;
  logic                 w_fifo_full;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // A key whose synchronised level differs from its accepted level is a
  // candidate; it is accepted once the difference has been seen on
  // STABLE_SAMPLES consecutive ticks. Any agreeing sample restarts the count.
  assign w_differ = r_sync2 ^ r_stable;

  generate
    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
      assign w_accept[gi]   = w_tick & w_differ[gi] & (r_cnt[gi] == CNT_LAST);
      assign w_cnt_next[gi] = !w_tick                        ? r_cnt[gi] :
                              (!w_differ[gi] || w_accept[gi]) ? '0 :
                                                                r_cnt[gi] + KEY_CNT_W'(1);
    end
  endgenerate

  assign w_stable_next = (r_stable & ~w_accept) | (r_sync2 & w_accept);

  // Press edge: accepted level goes released (1) -> pressed (0).
  assign w_press = w_accept & r_stable;

  // Synchroniser, tick divider, per-key debounce and the published key map.
  // key_state follows the next stable value so it always equals ~stable.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1     <= KEY_MAP_RST;
      r_sync2     <= KEY_MAP_RST;
      r_tick_cnt  <= '0;
      r_stable    <= KEY_MAP_RST;
      r_key_state <= '0;
      for (int i = 0; i < KEY_NUM; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1     <= key_in;
      r_sync2     <= r_sync1;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      r_stable    <= w_stable_next;
      r_key_state <= ~w_stable_next;
      for (int i = 0; i < KEY_NUM; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  // Lowest pending press is isolated with the two's-complement trick.
  assign w_press_sel = r_press_pend & (~r_press_pend + ONE_VEC);
  assign w_push      = w_any_pend & ~w_fifo_full;
  assign w_press_clr = w_push ? w_press_sel : '0;

  // A new edge is only lost if the earlier one is still waiting; if it is
  // being enqueued this very cycle the new edge simply re-arms the bit.
  assign w_press_lost = |(w_press & r_press_pend & ~w_press_clr);

`ifdef KEY_RELEASE_EVT_EN
  logic [KEY_NUM-1:0] r_rel_pend;
  logic [KEY_NUM-1:0] w_release;
  logic [KEY_NUM-1:0] w_rel_sel;
  logic [KEY_NUM-1:0] w_rel_clr;

  assign w_release   = w_accept & ~r_stable;
  assign w_rel_sel   = r_rel_pend & (~r_rel_pend + ONE_VEC);
  // Releases are only served when no press is waiting.
  assign w_rel_clr   = (w_push && (r_press_pend == '0)) ? w_rel_sel : '0;
  assign w_rel_lost  = |(w_release & r_rel_pend & ~w_rel_clr);
  assign w_any_pend  = (r_press_pend != '0) || (r_rel_pend != '0);
  assign w_push_code = (r_press_pend != '0) ? {1'b0, lowest_idx(r_press_pend)}
                                            : {1'b1, lowest_idx(r_rel_pend)};

  // Release pending bits: set on release edge (set wins over same-cycle clear).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rel_pend <= '0;
    end else begin
      r_rel_pend <= (r_rel_pend & ~w_rel_clr) | w_release;
    end
  end
`else
  assign w_rel_lost  = 1'b0;
  assign w_any_pend  = (r_press_pend != '0);
  assign w_push_code = lowest_idx(r_press_pend);
`endif

  // Press pending bits and the lost-event pulse (set wins over same-cycle clear).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_press_pend <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_press_pend <= (r_press_pend & ~w_press_clr) | w_press;
      r_overflow   <= w_press_lost | w_rel_lost;
    end
  end

  keypad_evt_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_push   (w_push),
    .i_data   (w_push_code),
    .o_full   (w_fifo_full),
    .i_pop    (key_ready),
    .o_head   (key_code),
    .o_valid  (key_valid)
  );

  assign key_state = r_key_state;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Self-checking bench for keypad_event_encoder (SAMPLE_DIV=4,
// STABLE_SAMPLES=2, FIFO_DEPTH=4). Expected key codes go into a scoreboard
// queue when keys are driven and are compared as the DUT hands them out.
// Build with KEY_RELEASE_EVT_EN defined to also expect release events.
module tb_keypad_event_encoder;
  import keypad_pkg::*;

`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif
  localparam key_code_t REL_FLAG = key_code_t'(1 << KEY_IDX_W);

  logic            clk;
  logic            rst_n;
  logic [15:0]     key_in;
  logic            key_ready;
  logic            key_valid;
  key_code_t       key_code;
  logic [15:0]     key_state;
  logic            overflow;

  int              checks;
  int              errors;
  int              ov_count;
  key_code_t       exp_q[$];
  logic [15:0]     exp_state;

  keypad_event_encoder #(
    .SAMPLE_DIV     (4),
    .STABLE_SAMPLES (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .key_in    (key_in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_state (key_state),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted beat must match the oldest expectation.
  always @(negedge clk) begin
    key_code_t exp_code;
    if (rst_n) begin
      if (overflow) ov_count++;
      if (key_valid && key_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: key_code=%0h, none expected", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (key_code !== exp_code) begin
            errors++;
            $display("FAIL event_code: key_code=%0h, expected %0h", key_code, exp_code);
          end else begin
            $display("event key_code=%0h ok", key_code);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue press events for newly pressed keys (lowest index first).
  task automatic exp_press(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) exp_q.push_back(key_code_t'(i));
    end
    exp_state = exp_state | mask;
  endtask

  // Queue release events (only produced when the release feature is built).
  task automatic exp_release(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      if (REL_EN && mask[i]) exp_q.push_back(key_code_t'(i) | REL_FLAG);
    end
    exp_state = exp_state & ~mask;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (key_state !== exp_state) begin
      errors++;
      $display("FAIL %s: key_state=%h, expected %h", name, key_state, exp_state);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    step(4);
  endtask

  task automatic test_reset();
    key_in = 16'hffff; key_ready = 1'b0; rst_n = 1'b0;
    step(3);
    checks++;
    if (key_valid !== 1'b0 || key_code !== '0 || key_state !== 16'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b code=%0h state=%h ovf=%b, expected 0 0 0000 0",
               key_valid, key_code, key_state, overflow);
    end
    rst_n = 1'b1;
    step(2);

    // Two entries in the FIFO, then reset asynchronously mid-cycle.
    key_in = ~16'h0006;
    step(16);
    checks++;
    if (key_valid !== 1'b1 || key_code !== key_code_t'(1)) begin
      errors++;
      $display("FAIL prereset_fifo: valid=%b code=%0h, expected 1 1", key_valid, key_code);
    end
    #2;
    rst_n = 1'b0;
    key_in = 16'hffff;
    #1;
    checks++;
    if (key_valid !== 1'b0 || key_state !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b state=%h, expected 0 0000", key_valid, key_state);
    end
    exp_q.delete();
    exp_state = 16'h0;
    step(3);

    // Counts restart from zero: exact latency from reset release.
    @(posedge clk); #1;
    rst_n = 1'b1;
    key_in = ~16'h0040;
    step(7);
    check_state("latency_state_before");
    step(1);
    exp_press(16'h0040);
    check_state("latency_state_accept");
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_valid_early: valid=%b, expected 0", key_valid);
    end
    step(1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== key_code_t'(6)) begin
      errors++;
      $display("FAIL latency_valid: valid=%b code=%0h, expected 1 6", key_valid, key_code);
    end
    key_ready = 1'b1;
    wait_drain("latency_drain");
    exp_release(16'h0040);
    key_in = 16'hffff;
    step(14);
    wait_drain("latency_release");
    check_state("latency_state_released");
  endtask

  task automatic test_single_press();
    int ov_base;
    ov_base = ov_count;
    key_ready = 1'b1;
    exp_press(16'h0020);
    key_in = ~16'h0020;
    step(12);
    check_state("single_state");
    wait_drain("single_drain");
    exp_release(16'h0020);
    key_in = 16'hffff;
    step(14);
    wait_drain("single_release");
    check_state("single_state_released");
    checks++;
    if (ov_count !== ov_base) begin
      errors++;
      $display("FAIL single_overflow: pulses=%0d, expected %0d", ov_count, ov_base);
    end
  endtask

  task automatic test_glitch();
    key_ready = 1'b1;
    key_in = ~16'h0200;
    step(4);
    key_in = 16'hffff;
    step(16);
    check_state("glitch_state");
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_event: valid=%b, expected 0", key_valid);
    end
  endtask

  task automatic test_simultaneous();
    key_ready = 1'b0;
    exp_press(16'h1088);
    key_in = ~16'h1088;
    step(14);
    check_state("simul_state");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== key_code_t'(3)) begin
        errors++;
        $display("FAIL simul_hold: cycle %0d valid=%b code=%0h, expected 1 3", i, key_valid, key_code);
      end
      step(1);
    end
    key_ready = 1'b1;
    wait_drain("simul_drain");
    exp_release(16'h1088);
    key_in = 16'hffff;
    step(14);
    wait_drain("simul_release");
    check_state("simul_state_released");
  endtask

  task automatic test_overflow();
    int ov_base;
    ov_base = ov_count;
    key_ready = 1'b0;
    exp_press(16'h001f);
    key_in = ~16'h001f;
    step(14);
    check_state("full_state");
    checks++;
    if (key_valid !== 1'b1 || key_code !== key_code_t'(0) || ov_count !== ov_base) begin
      errors++;
      $display("FAIL full_head: valid=%b code=%0h pulses=%0d, expected 1 0 %0d",
               key_valid, key_code, ov_count, ov_base);
    end
    // Release and re-press key 4 while its first press is still pending.
    exp_release(16'h0010);
    key_in = ~16'h000f;
    step(14);
    check_state("full_release4");
    key_in = ~16'h001f;
    exp_state = exp_state | 16'h0010;
    step(14);
    checks++;
    if (ov_count !== ov_base + 1) begin
      errors++;
      $display("FAIL overflow_pulse: pulses=%0d, expected %0d", ov_count, ov_base + 1);
    end
    // One pop makes room for the held press of key 4.
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    step(3);
    checks++;
    if (key_valid !== 1'b1 || key_code !== key_code_t'(1)) begin
      errors++;
      $display("FAIL after_one_pop: valid=%b code=%0h, expected 1 1", key_valid, key_code);
    end
    key_ready = 1'b1;
    wait_drain("overflow_drain");
    checks++;
    if (ov_count !== ov_base + 1) begin
      errors++;
      $display("FAIL overflow_once: pulses=%0d, expected %0d", ov_count, ov_base + 1);
    end
    exp_release(16'h001f);
    key_in = 16'hffff;
    step(14);
    wait_drain("overflow_release");
    check_state("overflow_state_released");
  endtask

`ifdef KEY_RELEASE_EVT_EN
  task automatic test_release_evt();
    key_ready = 1'b0;
    exp_press(16'h0400);
    key_in = ~16'h0400;
    step(14);
    exp_release(16'h0400);
    key_in = 16'hffff;
    step(14);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 5'h0A) begin
      errors++;
      $display("FAIL release_first: valid=%b code=%0h, expected 1 0a", key_valid, key_code);
    end
    key_ready = 1'b1;
    wait_drain("release_drain");
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    ov_count  = 0;
    exp_state = 16'h0;
    rst_n     = 1'b0;
    key_in    = 16'hffff;
    key_ready = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
`ifdef KEY_RELEASE_EVT_EN
    test_release_evt();
`endif
    step(4);
    checks++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: outstanding=%0d valid=%b, expected 0 0", exp_q.size(), key_valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
